// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types and constants for the transmit frame buffer
package eth_tx_pkg;

    // {bytes_valid[2:0], data[31:0]}
    typedef logic [34:0] tx_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } txbuf_state_t;

    localparam int ETH_MAX_WORDS = 384;

endpackage

// File: rtl/ethernet_tx_frame_ram.sv
// rtl/ethernet_tx_frame_ram.sv - simple dual-port frame RAM with registered read
module ethernet_tx_frame_ram
    import eth_tx_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [34:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [34:0]   rd_data
);

    tx_word_t mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register is cleared so the MAC-facing data bus starts at zero.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ethernet_tx_frame_buffer.sv
// rtl/ethernet_tx_frame_buffer.sv - store-and-forward transmit frame buffer toward the MAC
module ethernet_tx_frame_buffer
    import eth_tx_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int FRAME_DEPTH = 32,
    parameter int MAX_WORDS   = ETH_MAX_WORDS
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         tx_l2_start,
    input  logic                         tx_l2_data_valid,
    input  logic [2:0]                   tx_l2_bytes_valid,
    input  logic [31:0]                  tx_l2_data,
    input  logic                         tx_l2_commit,
    input  logic                         tx_l2_drop,
    input  logic                         tx_frame_ready,
    output logic                         tx_frame_data_valid,
    output logic [2:0]                   tx_frame_bytes_valid,
    output logic [31:0]                  tx_frame_data,
    output logic                         tx_push_dropped,
    output logic [$clog2(FRAME_DEPTH):0] tx_frames_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int FW = $clog2(FRAME_DEPTH);
    localparam logic [PW-1:0] RAM_CAP = PW'(DEPTH);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [FW:0]   LF_CAP  = (FW + 1)'(FRAME_DEPTH);

    logic [PW-1:0] wr_commit_ptr, wr_tent_ptr, rd_ptr, used, tent_next;
    logic [CW-1:0] word_cnt, cnt_next, remaining;
    logic          in_frame, ovf, ovf_next;
    logic [CW-1:0] len_fifo [FRAME_DEPTH];
    logic [FW:0]   lf_wp, lf_rp;
    logic          lf_full, lf_empty;
    logic          wr_accept, commit_req, drop_req, commit_ok, commit_bad;
    logic          rd_en, last_rd, send_valid;
    tx_word_t      rd_word;
    txbuf_state_t  state;

    always_comb begin
        used       = wr_tent_ptr - rd_ptr;
        lf_full    = (lf_wp - lf_rp) == LF_CAP;
        lf_empty   = lf_wp == lf_rp;
        wr_accept  = in_frame && tx_l2_data_valid && (used != RAM_CAP) && (word_cnt < MAX_CNT);
        tent_next  = wr_tent_ptr + PW'(wr_accept);
        cnt_next   = word_cnt + CW'(wr_accept);
        ovf_next   = ovf || (in_frame && tx_l2_data_valid && !wr_accept);
        // Drop outranks commit; both only mean something inside an open frame.
        drop_req   = in_frame && tx_l2_drop;
        commit_req = in_frame && tx_l2_commit && !tx_l2_drop;
        commit_bad = commit_req && (ovf_next || cnt_next == '0 || lf_full);
        commit_ok  = commit_req && !commit_bad;
        rd_en      = state == SEND;
        last_rd    = rd_en && remaining == CW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && commit_ok) begin
            len_fifo[lf_wp[FW-1:0]] <= cnt_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_commit_ptr     <= '0;
            wr_tent_ptr       <= '0;
            rd_ptr            <= '0;
            word_cnt          <= '0;
            remaining         <= '0;
            in_frame          <= 1'b0;
            ovf               <= 1'b0;
            lf_wp             <= '0;
            lf_rp             <= '0;
            state             <= IDLE;
            send_valid        <= 1'b0;
            tx_push_dropped   <= 1'b0;
            tx_frames_pending <= '0;
        end else begin
            tx_push_dropped <= commit_bad;
            send_valid      <= rd_en;
            ovf             <= ovf_next;
            if (wr_accept) begin
                wr_tent_ptr <= tent_next;
                word_cnt    <= cnt_next;
            end
            if (drop_req || commit_bad) begin
                wr_tent_ptr <= wr_commit_ptr;
                in_frame    <= 1'b0;
            end else if (commit_ok) begin
                wr_commit_ptr <= tent_next;
                lf_wp         <= lf_wp + 1'b1;
                in_frame      <= 1'b0;
            end
            if (tx_l2_start) begin
                wr_tent_ptr <= commit_ok ? tent_next : wr_commit_ptr;
                word_cnt    <= '0;
                ovf         <= 1'b0;
                in_frame    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!lf_empty && tx_frame_ready) begin
                        remaining <= len_fifo[lf_rp[FW-1:0]];
                        lf_rp     <= lf_rp + 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (last_rd) begin
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (commit_ok && !last_rd) begin
                tx_frames_pending <= tx_frames_pending + 1'b1;
            end else if (last_rd && !commit_ok) begin
                tx_frames_pending <= tx_frames_pending - 1'b1;
            end
        end
    end

    ethernet_tx_frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_tent_ptr[AW-1:0]),
        .wr_data ({tx_l2_bytes_valid, tx_l2_data}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    assign tx_frame_data_valid  = send_valid;
    assign tx_frame_bytes_valid = send_valid ? rd_word[34:32] : 3'd0;
    assign tx_frame_data        = rd_word[31:0];

endmodule

// File: tb/tb_ethernet_tx_frame_buffer.sv
// tb/tb_ethernet_tx_frame_buffer.sv - scoreboard bench for the transmit frame buffer
module tb_ethernet_tx_frame_buffer;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tx_l2_start = 1'b0;
    logic        tx_l2_data_valid = 1'b0;
    logic [2:0]  tx_l2_bytes_valid = 3'd0;
    logic [31:0] tx_l2_data = 32'd0;
    logic        tx_l2_commit = 1'b0;
    logic        tx_l2_drop = 1'b0;
    logic        tx_frame_ready = 1'b0;
    logic        tx_frame_data_valid;
    logic [2:0]  tx_frame_bytes_valid;
    logic [31:0] tx_frame_data;
    logic        tx_push_dropped;
    logic [5:0]  tx_frames_pending;

    ethernet_tx_frame_buffer dut (
        .sys_clk              (sys_clk),
        .sys_rst              (sys_rst),
        .tx_l2_start          (tx_l2_start),
        .tx_l2_data_valid     (tx_l2_data_valid),
        .tx_l2_bytes_valid    (tx_l2_bytes_valid),
        .tx_l2_data           (tx_l2_data),
        .tx_l2_commit         (tx_l2_commit),
        .tx_l2_drop           (tx_l2_drop),
        .tx_frame_ready       (tx_frame_ready),
        .tx_frame_data_valid  (tx_frame_data_valid),
        .tx_frame_bytes_valid (tx_frame_bytes_valid),
        .tx_frame_data        (tx_frame_data),
        .tx_push_dropped      (tx_push_dropped),
        .tx_frames_pending    (tx_frames_pending)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int drops = 0;
    int frames_seen = 0;
    int run_len = 0;
    logic [31:0] last_data = 32'd0;
    logic [34:0] exp_words[$];
    int          exp_lens[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            exp_words.delete();
            exp_lens.delete();
            run_len = 0;
        end else begin
            if (tx_push_dropped) drops++;
            if (tx_frame_data_valid) begin
                if (exp_words.size() == 0) begin
                    check("unexpected_word", 64'({tx_frame_bytes_valid, tx_frame_data}), 64'h0);
                    if ({tx_frame_bytes_valid, tx_frame_data} == 35'd0) begin
                        errors++;
                        $display("FAIL unexpected_word: valid with empty scoreboard");
                    end
                end else begin
                    check("word", 64'({tx_frame_bytes_valid, tx_frame_data}), 64'(exp_words.pop_front()));
                end
                run_len++;
                last_data = tx_frame_data;
            end else if (run_len > 0) begin
                frames_seen++;
                if (exp_lens.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_len: got %0d words, no frame expected", run_len);
                end else begin
                    check("frame_len", 64'(run_len), 64'(exp_lens.pop_front()));
                end
                check("gap_bytes", 64'(tx_frame_bytes_valid), 64'h0);
                check("gap_data_hold", 64'(tx_frame_data), 64'(last_data));
                run_len = 0;
            end
        end
    end

    task automatic push_frame(input int n, input logic [2:0] last_bytes, input logic [15:0] tag,
                              input bit do_commit, input bit expect_out);
        if (expect_out) exp_lens.push_back(n);
        @(posedge sys_clk); #1;
        tx_l2_start = 1'b1;
        @(posedge sys_clk); #1;
        tx_l2_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            tx_l2_data_valid  = 1'b1;
            tx_l2_data        = {tag, 16'(i)};
            tx_l2_bytes_valid = (i == n - 1) ? last_bytes : 3'd4;
            tx_l2_commit      = do_commit && (i == n - 1);
            if (expect_out) exp_words.push_back({tx_l2_bytes_valid, tx_l2_data});
            @(posedge sys_clk); #1;
        end
        tx_l2_data_valid = 1'b0;
        tx_l2_commit     = 1'b0;
        if (!do_commit) begin
            tx_l2_drop = 1'b1;
            @(posedge sys_clk); #1;
            tx_l2_drop = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_words.size() != 0 || run_len != 0 || exp_lens.size() != 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words still expected", exp_words.size());
        end
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        int cyc;
        int d0;
        int f0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_valid", 64'(tx_frame_data_valid), 64'h0);
        check("rst_bytes", 64'(tx_frame_bytes_valid), 64'h0);
        check("rst_data", 64'(tx_frame_data), 64'h0);
        check("rst_dropped", 64'(tx_push_dropped), 64'h0);
        check("rst_pending", 64'(tx_frames_pending), 64'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // 1: 64-byte frame, first word two cycles after ready
        push_frame(16, 3'd4, 16'hA001, 1'b1, 1'b1);
        @(negedge sys_clk);
        check("t1_pending", 64'(tx_frames_pending), 64'd1);
        @(posedge sys_clk); #1;
        tx_frame_ready = 1'b1;
        cyc = 0;
        @(negedge sys_clk);
        while (!tx_frame_data_valid && cyc < 20) begin
            cyc++;
            @(negedge sys_clk);
        end
        check("t1_latency", 64'(cyc), 64'd2);
        wait_drain(200);
        check("t1_pending_done", 64'(tx_frames_pending), 64'd0);

        // 2: 61-byte frame followed by a second frame, both queued before release
        tx_frame_ready = 1'b0;
        push_frame(16, 3'd1, 16'hB002, 1'b1, 1'b1);
        push_frame(8, 3'd3, 16'hB003, 1'b1, 1'b1);
        @(negedge sys_clk);
        check("t2_pending", 64'(tx_frames_pending), 64'd2);
        @(posedge sys_clk); #1;
        tx_frame_ready = 1'b1;
        wait_drain(300);

        // 3: dropped frame then a committed 5-word frame
        d0 = drops;
        push_frame(10, 3'd4, 16'hC004, 1'b0, 1'b0);
        push_frame(5, 3'd2, 16'hC005, 1'b1, 1'b1);
        wait_drain(200);
        check("t3_no_dropped_pulse", 64'(drops - d0), 64'd0);

        // 4: over-length frame is discarded at commit
        d0 = drops;
        f0 = frames_seen;
        push_frame(400, 3'd4, 16'hD006, 1'b1, 1'b0);
        repeat (2) @(negedge sys_clk);
        check("t4_pending", 64'(tx_frames_pending), 64'd0);
        repeat (10) @(negedge sys_clk);
        check("t4_dropped_once", 64'(drops - d0), 64'd1);
        check("t4_no_output", 64'(frames_seen - f0), 64'd0);

        // 5: RAM fill with the MAC held off; third frame overflows
        @(posedge sys_clk); #1;
        tx_frame_ready = 1'b0;
        d0 = drops;
        f0 = frames_seen;
        push_frame(384, 3'd4, 16'hE007, 1'b1, 1'b1);
        push_frame(384, 3'd4, 16'hE008, 1'b1, 1'b1);
        push_frame(384, 3'd4, 16'hE009, 1'b1, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("t5_dropped", 64'(drops - d0), 64'd1);
        check("t5_pending", 64'(tx_frames_pending), 64'd2);
        @(posedge sys_clk); #1;
        tx_frame_ready = 1'b1;
        wait_drain(2000);
        check("t5_frames_out", 64'(frames_seen - f0), 64'd2);
        check("t5_pending_done", 64'(tx_frames_pending), 64'd0);

        // 6: reset during the fifth outgoing word, then a clean frame
        push_frame(16, 3'd4, 16'hF00A, 1'b1, 1'b1);
        cyc = 0;
        @(negedge sys_clk);
        while (!tx_frame_data_valid && cyc < 50) begin
            cyc++;
            @(negedge sys_clk);
        end
        if (cyc >= 50) begin
            checks++;
            errors++;
            $display("FAIL t6_start_timeout: no output word");
        end
        repeat (4) @(negedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_valid_after_rst", 64'(tx_frame_data_valid), 64'h0);
        check("t6_pending_after_rst", 64'(tx_frames_pending), 64'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        push_frame(6, 3'd2, 16'hF00B, 1'b1, 1'b1);
        wait_drain(200);
        check("t6_pending_done", 64'(tx_frames_pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
